// File: rtl/uart_tx_fifo_if.sv
// Byte-write handshake into the UART transmit FIFO.
// The producer drives data/valid; the FIFO answers with ready.
interface uart_tx_fifo_if;
   logic [7:0] wr_data;
   logic       wr_valid;
   logic       wr_ready;

   modport master (output wr_data, output wr_valid, input wr_ready);
   modport slave  (input wr_data, input wr_valid, output wr_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small circular byte FIFO.
// A frame starts two edges after a byte lands in an empty FIFO; queued bytes go out back-to-back.
module uart_tx_fifo #(
   parameter int CLK_DIV    = 5208,
   parameter int FIFO_DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   uart_tx_fifo_if.slave    wr,
   output logic             txd,
   output logic             busy,
   output logic [4:0]       fifo_count
);

   localparam int          PTR_W    = $clog2(FIFO_DEPTH);
   localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
   localparam logic [4:0]  DEPTH    = 5'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   logic [7:0]       mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [4:0]       count_q, count_d;
   state_t           state_q, state_d;
   logic [15:0]      cnt_q, cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic             txd_q, txd_d;
   logic             push, pop, bit_done;

   // Ready depends only on the registered count, so a same-cycle pop never frees a full FIFO.
   assign wr.wr_ready = (count_q != DEPTH);
   assign push        = wr.wr_valid && wr.wr_ready && !rst;
   assign bit_done    = (cnt_q == DIV_LAST);

   // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      pop       = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (count_q != 5'd0) begin
               pop     = 1'b1;
               shift_d = mem_q[rd_ptr_q];
               state_d = START;
            end
         end
         START: begin
            if (bit_done) begin
               cnt_d     = '0;
               bit_idx_d = '0;
               state_d   = DATA;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         DATA: begin
            if (bit_done) begin
               cnt_d   = '0;
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_idx_q == 3'd7) begin
                  state_d = STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         STOP: begin
            if (bit_done) begin
               cnt_d = '0;
               if (count_q != 5'd0) begin
                  pop     = 1'b1;
                  shift_d = mem_q[rd_ptr_q];
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // The line follows the current state, registered, so it trails the FSM by one cycle.
   always_comb begin
      case (state_q)
         START:   txd_d = 1'b0;
         DATA:    txd_d = shift_q[0];
         default: txd_d = 1'b1;
      endcase
   end

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 5'd1;
         2'b01:   count_d = count_q - 5'd1;
         default: count_d = count_q;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         txd_q     <= 1'b1;
         count_q   <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
      end else begin
         state_q   <= state_d;
         txd_q     <= txd_d;
         count_q   <= count_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
      end
   end

   // NOTE: storage is not reset; the count and pointers alone decide which entries are valid.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wr.wr_data;
   end

   assign txd        = txd_q;
   assign busy       = (state_q != IDLE) || (count_q != 5'd0);
   assign fifo_count = count_q;

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLK_DIV, default 5208, meaning clk cycles per bit (50 MHz / 9600 baud); legal range 2..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning byte entries; power of two, 2..16.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning reset: synchronous, active-high.
REQ-005 SHALL have port wr_data, input, 8, meaning the byte to transmit.
REQ-006 SHALL have port wr_valid, input, 1, meaning wr_data is offered.
REQ-007 SHALL have port wr_ready, output, 1, meaning the FIFO can accept a byte this cycle.
REQ-008 SHALL have port txd, output, 1, meaning the serial line, idle high.
REQ-009 SHALL have port busy, output, 1, meaning a frame is in progress or the FIFO is non-empty.
REQ-010 SHALL have port fifo_count, output, 5, meaning the number of bytes stored in the FIFO (0..FIFO_DEPTH).

Function
REQ-011 SHALL accept a byte on any rising edge where wr_valid=1 and wr_ready=1; wr_data is ignored otherwise.
REQ-012 SHALL drive wr_ready = (fifo_count != FIFO_DEPTH), combinationally from registered count; a pop in the same cycle SHALL NOT make a full FIFO ready.
REQ-013 SHALL update fifo_count by +1 on write only, -1 on pop only, and leave it unchanged on simultaneous write and pop.
REQ-014 SHALL use circular read/write pointers that wrap from FIFO_DEPTH-1 to 0, preserving byte order.
REQ-015 SHALL frame each byte as 8N1: one start bit (0), eight data bits LSB first, one stop bit (1).
REQ-016 SHALL hold every bit on txd for exactly CLK_DIV clk cycles, timed by a bit counter that reloads at each bit boundary.
REQ-017 SHALL implement FSM states IDLE, START, DATA, STOP.
- IDLE: txd=1; if fifo_count>0, pop the head into the shift register and go to START.
- START: txd=0 for CLK_DIV cycles, then DATA with bit index 0.
- DATA: txd=shift[0]; shift right after every CLK_DIV cycles; after bit index 7, go to STOP.
- STOP: txd=1 for CLK_DIV cycles; then pop and go directly to START if the FIFO is non-empty, else go to IDLE.
REQ-018 SHALL register txd (no combinational path to the pin).
REQ-019 SHALL drive txd low on the 2nd rising edge after the edge that writes a byte into an empty FIFO with the FSM in IDLE.
REQ-020 SHALL transmit back-to-back frames with no idle gap: frame period exactly 10*CLK_DIV cycles while the FIFO stays non-empty.
REQ-021 SHALL assert busy = (state != IDLE) or (fifo_count != 0).
REQ-022 SHALL keep writes accepted during a frame from altering the byte in flight.

Reset
REQ-023 SHALL, on rst=1 at a rising edge, set state=IDLE, txd=1, fifo_count=0, pointers=0, bit counter=0, shift register=0; busy=0 and wr_ready=1 thereafter.
REQ-024 SHALL, when reset arrives mid-frame, abort the frame (txd=1 from the next cycle) and discard all queued bytes.
REQ-025 SHALL ignore wr_valid during any cycle in which rst=1.

Verification (CLK_DIV=4, FIFO_DEPTH=8)
REQ-026 SHALL cover a single byte: write 0x77 into an idle unit -> txd low 2 edges later, then line pattern 0,1,1,1,0,1,1,1,0,1 with each bit held 4 cycles; busy falls after the stop bit.
REQ-027 SHALL cover back-to-back traffic: burst-write "welcome" (0x77,0x65,0x6C,0x63,0x6F,0x6D,0x65) -> 7 contiguous frames over 280 cycles, in order, with no idle high gap between stop and start bits.
REQ-028 SHALL cover a full FIFO: hold wr_valid=1 during a frame until fifo_count=8 -> wr_ready=0, the 9th byte is not accepted, and after the next pop wr_ready=1 with count 7.
REQ-029 SHALL cover simultaneous write and pop: write a byte on the exact STOP-to-START pop edge with count=3 -> count stays 3 and the byte order is preserved.
REQ-030 SHALL cover reset mid-frame: assert rst during DATA bit 4 with 3 bytes queued -> txd=1, count=0, busy=0 next cycle; a subsequent write of 0xA5 is sent cleanly.
REQ-031 SHALL cover pointer wrap-around: stream 20 incrementing bytes (0x00..0x13) -> all 20 are received in order by a bench UART monitor with no framing errors.
